// File: rtl/matmul_sequencer.sv
// matmul_sequencer: control FSM walking the (i, j, k) loop nest of an N x N
// matrix multiply C = A x B. Per output element it clears the accumulator,
// runs N multiply-accumulate cycles, then writes the element to C.
//
// Host/datapath handshake: Start is sampled only in IDLE. Stall is a
// not-ready from the datapath/memory: while high, state and counters hold and
// the strobes (Acc_Clr, Acc_En, C_We) are gated low, so a strobe is only ever
// seen in a cycle where Stall is low. Abort is a synchronous cancel that wins
// over Stall and returns to IDLE without Done.
module matmul_sequencer #(
  parameter int N      = 4,
  parameter int AW     = 8,
  parameter int A_BASE = 0,
  parameter int B_BASE = 16,
  parameter int C_BASE = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Abort,
  input  logic          Stall,
  output logic [AW-1:0] A_Addr,
  output logic [AW-1:0] B_Addr,
  output logic [AW-1:0] C_Addr,
  output logic          Acc_Clr,
  output logic          Acc_En,
  output logic          C_We,
  output logic          Busy,
  output logic          Done,
  output logic [2:0]    Dbg_State
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [AW-1:0] A_B  = AW'(A_BASE);
  localparam logic [AW-1:0] B_B  = AW'(B_BASE);
  localparam logic [AW-1:0] C_B  = AW'(C_BASE);
  localparam logic [AW-1:0] N_AW = AW'(N);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_MAC   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] i_q, j_q, k_q;
  logic [CW-1:0] i_d, j_d, k_d;
  logic [AW-1:0] i_ext, j_ext, k_ext;

  // State and loop counters; asynchronous active-low reset to IDLE / zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else begin
      state <= state_d;
      i_q   <= i_d;
      j_q   <= j_d;
      k_q   <= k_d;
    end
  end

  // Next state and counters: Abort beats Stall, Stall freezes sequencing.
  always_comb begin
    state_d = state;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    if (state != S_IDLE && Abort) begin
      state_d = S_IDLE;
      i_d     = '0;
      j_d     = '0;
      k_d     = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start) begin
            state_d = S_CLEAR;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
          end
        end
        S_CLEAR: begin
          if (!Stall) begin
            state_d = S_MAC;
            k_d     = '0;
          end
        end
        S_MAC: begin
          if (!Stall) begin
            if (k_q == LAST) state_d = S_WRITE;
            else             k_d     = k_q + ONE;
          end
        end
        S_WRITE: begin
          if (!Stall) begin
            k_d = '0;
            if (j_q == LAST) begin
              j_d = '0;
              if (i_q == LAST) begin
                i_d     = '0;
                state_d = S_DONE;
              end else begin
                i_d     = i_q + ONE;
                state_d = S_CLEAR;
              end
            end else begin
              j_d     = j_q + ONE;
              state_d = S_CLEAR;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign i_ext = AW'(i_q);
  assign j_ext = AW'(j_q);
  assign k_ext = AW'(k_q);

  // Moore outputs from registered state/counters; only Stall gates strobes.
  always_comb begin
    A_Addr  = '0;
    B_Addr  = '0;
    C_Addr  = '0;
    Acc_Clr = 1'b0;
    Acc_En  = 1'b0;
    C_We    = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    case (state)
      S_CLEAR, S_MAC, S_WRITE: begin
        Busy   = 1'b1;
        A_Addr = A_B + i_ext * N_AW + k_ext;
        B_Addr = B_B + k_ext * N_AW + j_ext;
        C_Addr = C_B + i_ext * N_AW + j_ext;
        Acc_Clr = (state == S_CLEAR) && !Stall;
        Acc_En  = (state == S_MAC)   && !Stall;
        C_We    = (state == S_WRITE) && !Stall;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Dbg_State = state;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed bench for matmul_sequencer with N=4 defaults.
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge of the same cycle by tick().
module tb_matmul_sequencer;
  localparam int N  = 4;
  localparam int AW = 8;

  // Clock / reset
  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b0;
  logic Abort = 1'b0;
  logic Stall = 1'b0;
  always #5 Clk = ~Clk;

  logic [AW-1:0] A_Addr, B_Addr, C_Addr;
  logic          Acc_Clr, Acc_En, C_We, Busy, Done;
  logic [2:0]    Dbg_State;

  matmul_sequencer #(.N(N), .AW(AW), .A_BASE(0), .B_BASE(16), .C_BASE(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .Stall(Stall),
    .A_Addr(A_Addr), .B_Addr(B_Addr), .C_Addr(C_Addr),
    .Acc_Clr(Acc_Clr), .Acc_En(Acc_En), .C_We(C_We),
    .Busy(Busy), .Done(Done), .Dbg_State(Dbg_State)
  );

  int checks = 0;
  int errors = 0;
  int cnt_busy, cnt_en, cnt_we, cnt_clr, cnt_done;

  logic [AW-1:0] l_a, l_b, l_c;
  logic          l_clr, l_en, l_we, l_busy, l_done, l_prev_we;
  logic [2:0]    l_state;

  logic [AW-1:0] a_log [0:95];
  logic [AW-1:0] b_log [0:95];
  logic [AW-1:0] c_log [0:95];
  logic          clr_log [0:95];
  logic          we_log [0:95];

  int exp_a [4] = '{4, 5, 6, 7};
  int exp_b [4] = '{18, 22, 26, 30};
  bit seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample on the falling edge, return 1 unit after rise.
  task automatic tick();
    @(negedge Clk);
    l_prev_we = l_we;
    l_a = A_Addr; l_b = B_Addr; l_c = C_Addr;
    l_clr = Acc_Clr; l_en = Acc_En; l_we = C_We;
    l_busy = Busy; l_done = Done; l_state = Dbg_State;
    cnt_busy += (Busy    === 1'b1) ? 1 : 0;
    cnt_en   += (Acc_En  === 1'b1) ? 1 : 0;
    cnt_we   += (C_We    === 1'b1) ? 1 : 0;
    cnt_clr  += (Acc_Clr === 1'b1) ? 1 : 0;
    cnt_done += (Done    === 1'b1) ? 1 : 0;
    @(posedge Clk);
    #1;
  endtask

  task automatic clr_counts();
    cnt_busy = 0; cnt_en = 0; cnt_we = 0; cnt_clr = 0; cnt_done = 0;
  endtask

  task automatic run_to_done(input int budget, output bit found);
    found = 1'b0;
    for (int c = 0; c < budget && !found; c++) begin
      tick();
      if (l_done === 1'b1) found = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_counts();
    l_we = 1'b0;

    // Reset state: outputs zero while reset is held.
    #1;
    chk("reset_outputs", {A_Addr, B_Addr, C_Addr, Acc_Clr, Acc_En, C_We, Busy, Done}, 0);
    chk("reset_state", Dbg_State, 0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b1;
    tick();
    chk("idle_after_release", l_state, 0);

    // Run 1: single-cycle Start, Start pulse mid-run ignored.
    clr_counts();
    Start = 1'b1;
    tick();
    chk("start_cycle_not_busy", l_busy, 0);
    for (int c = 0; c < 96; c++) begin
      Start = (c == 50);
      tick();
      a_log[c] = l_a; b_log[c] = l_b; c_log[c] = l_c;
      clr_log[c] = l_clr; we_log[c] = l_we;
    end
    Start = 1'b0;
    tick();
    chk("run1_done", l_done, 1);
    chk("run1_done_busy", l_busy, 0);
    chk("run1_done_after_write", l_prev_we, 1);
    tick();
    chk("run1_idle_outputs", {l_a, l_b, l_c, l_clr, l_en, l_we, l_busy, l_done}, 0);
    chk("run1_idle_state", l_state, 0);
    chk("run1_busy_cycles", cnt_busy, 96);
    chk("run1_acc_en", cnt_en, 64);
    chk("run1_c_we", cnt_we, 16);
    chk("run1_acc_clr", cnt_clr, 16);
    chk("run1_done_count", cnt_done, 1);
    chk("first_mac_a", a_log[1], 0);
    chk("first_mac_b", b_log[1], 16);
    chk("last_write_c", c_log[95], 47);

    // Element (1,2) trace: clear at cycle 36, MAC 37..40, write at 41.
    chk("e12_clear", clr_log[36], 1);
    for (int p = 0; p < 4; p++) begin
      chk("e12_a_addr", a_log[37+p], exp_a[p]);
      chk("e12_b_addr", b_log[37+p], exp_b[p]);
    end
    chk("e12_write", we_log[41], 1);
    chk("e12_c_addr", c_log[41], 38);

    // Run 2: stall three cycles at MAC k=1 of element (0,0).
    clr_counts();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("stall_run_clear", l_clr, 1);
    tick();
    chk("stall_run_mac0_a", l_a, 0);
    chk("stall_run_mac0_en", l_en, 1);
    Stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("stalled_en", l_en, 0);
      chk("stalled_a", l_a, 1);
      chk("stalled_b", l_b, 20);
      chk("stalled_busy", l_busy, 1);
    end
    Stall = 1'b0;
    tick();
    chk("resume_en", l_en, 1);
    chk("resume_a", l_a, 1);
    chk("resume_b", l_b, 20);
    run_to_done(200, seen);
    chk("stall_run_done_seen", seen, 1);
    chk("stall_run_busy", cnt_busy, 99);
    chk("stall_run_acc_en", cnt_en, 64);
    chk("stall_run_c_we", cnt_we, 16);
    chk("stall_run_acc_clr", cnt_clr, 16);
    tick();

    // Run 3: Abort during WRITE of element (2,3) (cycle 71).
    clr_counts();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 0; c < 71; c++) tick();
    Abort = 1'b1;
    tick();
    chk("abort_in_write_state", l_state, 3);
    chk("abort_in_write_we", l_we, 1);
    chk("abort_in_write_c", l_c, 43);
    Abort = 1'b0;
    tick();
    chk("abort_idle_state", l_state, 0);
    chk("abort_idle_we", l_we, 0);
    chk("abort_idle_busy", l_busy, 0);
    repeat (3) tick();
    chk("abort_no_done", cnt_done, 0);
    chk("abort_we_count", cnt_we, 12);

    // Abort together with Stall: Abort wins.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Stall = 1'b1;
    Abort = 1'b1;
    tick();
    chk("abort_stall_en", l_en, 0);
    Stall = 1'b0;
    Abort = 1'b0;
    tick();
    chk("abort_stall_idle", l_state, 0);
    chk("abort_stall_busy", l_busy, 0);

    // Start held high: Done, one IDLE cycle, then CLEAR again.
    clr_counts();
    Start = 1'b1;
    tick();
    for (int c = 0; c < 96; c++) tick();
    tick();
    chk("held_done", l_done, 1);
    tick();
    chk("held_idle_state", l_state, 0);
    chk("held_idle_busy", l_busy, 0);
    tick();
    chk("held_restart_state", l_state, 1);
    chk("held_restart_clr", l_clr, 1);
    chk("held_restart_busy", l_busy, 1);
    Start = 1'b0;
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    tick();
    chk("held_abort_idle", l_state, 0);

    // Asynchronous reset between edges in MAC.
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    #2;
    Reset = 1'b0;
    #1;
    chk("async_reset_outputs", {A_Addr, B_Addr, C_Addr, Acc_Clr, Acc_En, C_We, Busy, Done}, 0);
    chk("async_reset_state", Dbg_State, 0);
    @(posedge Clk); #1;
    Reset = 1'b1;
    tick();
    chk("post_reset_idle", l_state, 0);
    clr_counts();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    chk("post_reset_mac_a", l_a, 0);
    chk("post_reset_mac_b", l_b, 16);
    run_to_done(200, seen);
    chk("post_reset_done_seen", seen, 1);
    chk("post_reset_busy", cnt_busy, 96);
    chk("post_reset_acc_en", cnt_en, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Control FSM that sequences the matrix-multiply datapath to compute C = A × B for square N×N matrices held in row-major data memory. It walks the (i, j, k) loop nest, issues A/B read addresses, accumulator clear/enable strobes and C write strobes, and reports Busy/Done to the host. It sits between the host start logic and the Datapath, replacing hand-driven control words.

## Interface
- N, 4: matrix dimension; N ≥ 2.
- AW, 8: address width.
- A_BASE, 0: base address of A.
- B_BASE, 16: base address of B.
- C_BASE, 32: base address of C.
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset; one clock, reset asynchronous and active-low.
- Start  input  1  begin a multiply; sampled only in IDLE.
- Abort  input  1  synchronous cancel; returns to IDLE without Done.
- Stall  input  1  datapath/memory not ready; freezes sequencing.
- A_Addr  output  AW  read address for A operand.
- B_Addr  output  AW  read address for B operand.
- C_Addr  output  AW  write address for the C element.
- Acc_Clr  output  1  clear datapath accumulator.
- Acc_En  output  1  accumulate A×B product this cycle.
- C_We  output  1  write accumulator to C_Addr.
- Busy  output  1  high in CLEAR, MAC and WRITE.
- Done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, CLEAR, MAC, WRITE, DONE. Counters i, j, k each $clog2(N) bits.
- IDLE: all strobes 0, addresses 0. Start=1 → CLEAR, i=j=k=0.
- CLEAR: Acc_Clr=1, k=0 → MAC.
- MAC: Acc_En=1, A_Addr=A_BASE+i·N+k, B_Addr=B_BASE+k·N+j. k=N−1 → WRITE, else k+1.
- WRITE: C_We=1, C_Addr=C_BASE+i·N+j. Then j+1; j=N−1 wraps j=0, i+1; i=N−1 and j=N−1 → DONE, else → CLEAR.
- DONE: Done=1 for one cycle, Busy=0 → IDLE.
- Address arithmetic in AW bits, modulo 2^AW; base+N·N−1 ≥ 2^AW wraps silently (configuration error, not detected).
- Stall=1: state and counters hold; Acc_Clr, Acc_En, C_We forced 0 (combinational gate); addresses hold current values. Stall ignored in IDLE and DONE.
- Abort=1 in any non-IDLE state → IDLE next edge, counters cleared, no Done. Priority: Reset > Abort > Stall > normal sequencing.
- Start while Busy or in DONE ignored; Start held high continuously restarts from IDLE after DONE (one IDLE cycle between runs).

## Timing
- Reset asserted: state IDLE, counters 0, every output 0 immediately (asynchronous); first transition possible on the first rising edge after release.
- Outputs are Moore functions of registered state/counters except the Stall gating of strobes; no combinational path from Start or Abort.
- Start sampled at edge E0 → CLEAR during the following cycle.
- Per element: 1 CLEAR + N MAC + 1 WRITE = N+2 cycles. Busy high for N²(N+2) unstalled cycles (96 for N=4); Done high in the cycle immediately after the last WRITE.
- Each stalled cycle extends Busy by exactly one cycle; strobe counts unchanged.
- Acc_En count per run = N³; C_We count = N²; Acc_Clr count = N².

## Test plan
- Reset then single-cycle Start (N=4, defaults) → Busy high exactly 96 cycles, Done one cycle after, then IDLE with all outputs 0; Acc_En count 64, C_We 16, Acc_Clr 16.
- Element (1,2) trace → MAC A_Addr 4,5,6,7 with B_Addr 18,22,26,30; WRITE C_Addr 38; preceding cycle Acc_Clr=1.
- Stall high 3 cycles during MAC k=1 of element (0,0) → Acc_En=0 and addresses frozen (A_Addr 1, B_Addr 20) while stalled, resumes at k=1, Busy lasts 99 cycles, strobe counts unchanged.
- Start pulsed mid-run → ignored, Done timing unchanged; Start held high throughout → Done, one IDLE cycle, CLEAR again.
- Abort asserted in WRITE of element (2,3) → IDLE next edge, no C_We that cycle after edge, no Done; Abort together with Stall → Abort wins.
- Reset asserted asynchronously mid-MAC (between edges) → all outputs 0 before next edge; after release, Start → full 96-cycle run from (0,0).
